// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
// Shared constants and helpers for the input conditioner and its per-bit
// debounce channel.
//   DEBOUNCE_DEFAULT : default stability count (enabled cycles)
//   WIDTH_DEFAULT    : default number of conditioned channels
//   cnt_width(n)     : counter width needed to count 0..n-1, never below 1
package input_conditioner_pkg;

  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int WIDTH_DEFAULT    = 8;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One conditioned bit: two-flop synchroniser, stability counter, debounced
// level flop and one-cycle rise/fall pulse flops.
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous active-high reset, clears every flop
//   ena   in  : advance enable for the counter/level; sync pair always runs
//   din   in  : raw asynchronous pad bit
//   dout  out : debounced level (registered)
//   rise  out : one-cycle pulse on dout 0->1 (registered)
//   fall  out : one-cycle pulse on dout 1->0 (registered)
//   flip  out : combinational "dout changes at the coming edge", used by the
//               top level to register its shared changed flag alongside the
//               pulses
// The channel is STABLE when the synchronised bit matches dout (cnt is 0)
// and PENDING while a mismatch is being counted; pending is exported so the
// state can be observed.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic flip,
  output logic pending
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             terminal;

  always_comb begin
    mismatch = s2 ^ dout;
    terminal = (cnt == CNT_LAST);
    // A flip needs an enabled edge; with ena low the pulses fall to 0.
    flip     = ena & mismatch & terminal;
    pending  = mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= flip & s2;
      fall <= flip & ~s2;
      if (ena) begin
        if (!mismatch) begin
          cnt <= '0;
        end else if (terminal) begin
          // Cleared at terminal count, so the counter never wraps.
          cnt  <= '0;
          dout <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Synchronises, debounces and edge-detects WIDTH raw pad inputs.
// Ports:
//   clk     in  1     : clock
//   rst     in  1     : synchronous active-high reset
//   ena     in  1     : advance enable (tile ena)
//   din     in  WIDTH : raw asynchronous pad inputs
//   dout    out WIDTH : debounced levels
//   rise    out WIDTH : one-cycle pulse per bit on 0->1
//   fall    out WIDTH : one-cycle pulse per bit on 1->0
//   changed out 1     : OR of all rise|fall, registered with the pulses
// All outputs are registered; there is no combinational din->output path.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be in 1..255");
  end

  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] pending;
  logic             any_pending;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .din    (din[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .flip   (flip[i]),
      .pending(pending[i])
    );
  end

  // Observation point: high while any channel is counting a mismatch.
  always_comb begin
    any_pending = |pending;
  end

  // Registered from the same next-edge flip terms that load the pulse flops,
  // so changed lines up with rise/fall in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |flip;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
// Bench for input_conditioner: a default instance (DEBOUNCE_CYCLES=4) and a
// short-debounce instance (DEBOUNCE_CYCLES=1) share one stimulus. A table of
// directed vectors checks the default instance edge by edge, a hand sequence
// checks the short instance, and a behavioural model checks both instances
// on every edge, including a randomised phase.
module tb_input_conditioner;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ena;
  logic [W-1:0] din;

  logic [W-1:0] dout_a, rise_a, fall_a;
  logic         changed_a;
  logic [W-1:0] dout_b, rise_b, fall_b;
  logic         changed_b;

  input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );

  input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b. The synchronised view of din
  // is simply the raw value captured two edges earlier; each bit then needs
  // deb[k] consecutive enabled disagreeing edges before its level follows.
  int           deb [2] = '{4, 1};
  logic [W-1:0] seen[$];
  int           run [2][W];
  logic [W-1:0] m_dout[2], m_rise[2], m_fall[2];
  logic         m_chg[2];

  task automatic model_edge();
    logic [W-1:0] synced;
    if (rst) begin
      seen.delete();
      seen.push_back('0);
      seen.push_back('0);
      for (int k = 0; k < 2; k++) begin
        m_dout[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0;
        for (int i = 0; i < W; i++) run[k][i] = 0;
      end
    end else begin
      synced = seen[0];
      void'(seen.pop_front());
      seen.push_back(din);
      for (int k = 0; k < 2; k++) begin
        m_rise[k] = '0;
        m_fall[k] = '0;
        if (ena) begin
          for (int i = 0; i < W; i++) begin
            if (synced[i] != m_dout[k][i]) begin
              run[k][i]++;
              if (run[k][i] == deb[k]) begin
                m_dout[k][i] = synced[i];
                run[k][i]    = 0;
                if (synced[i]) m_rise[k][i] = 1'b1;
                else           m_fall[k][i] = 1'b1;
              end
            end else begin
              run[k][i] = 0;
            end
          end
        end
        m_chg[k] = |(m_rise[k] | m_fall[k]);
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen by the edge,
  // then compare both instances just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_model_a"}, {dout_a, rise_a, fall_a, changed_a},
          {m_dout[0], m_rise[0], m_fall[0], m_chg[0]});
    check({tag, "_model_b"}, {dout_b, rise_b, fall_b, changed_b},
          {m_dout[1], m_rise[1], m_fall[1], m_chg[1]});
  endtask

  // ---------------- directed vector table (dut_a) ----------------
  typedef struct packed {
    logic         rst;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic e, input logic [W-1:0] d,
                     input logic [W-1:0] o, input logic [W-1:0] ri,
                     input logic [W-1:0] fa, input logic c);
    for (int j = 0; j < n; j++) tbl.push_back('{r, e, d, o, ri, fa, c});
  endtask

  task automatic check_b(input string name, input logic [W-1:0] o, input logic [W-1:0] ri,
                         input logic [W-1:0] fa, input logic c);
    check(name, {dout_b, rise_b, fall_b, changed_b}, {o, ri, fa, c});
  endtask

  // ---------------- driver / test sequence ----------------
  initial begin
    rst = 1'b1;
    ena = 1'b1;
    din = '0;

    // Reset held 2 cycles with all inputs high, then first debounce.
    add(2, 1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'hFE, 8'hFF, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'hFE, 8'hFE, 8'h00, 8'h01, 1);
    add(1, 0, 1, 8'hFE, 8'hFE, 8'h00, 8'h00, 0);
    // Clean step on bit 0, up then down.
    add(1, 1, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(1, 0, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'h00, 8'h01, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // Bit 3: 3-cycle glitch rejected, then 4-cycle pulse accepted.
    add(3, 0, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    add(6, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(4, 0, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h00, 8'h08, 8'h08, 8'h00, 1);
    add(3, 0, 1, 8'h00, 8'h08, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h08, 1);
    add(1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // Bit 5: two counts, ena low for 5 edges, then 2 more enabled edges.
    add(4, 0, 1, 8'h20, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h20, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h20, 8'h20, 8'h20, 8'h00, 1);
    add(1, 0, 1, 8'h20, 8'h20, 8'h00, 8'h00, 0);
    // Simultaneous rise on bit 1 and fall on bit 2.
    add(1, 1, 1, 8'h04, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'h04, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h04, 8'h04, 8'h04, 8'h00, 1);
    add(5, 0, 1, 8'h02, 8'h04, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h04, 1);
    add(1, 0, 1, 8'h02, 8'h02, 8'h00, 8'h00, 0);
    // Bit 1: reset after 3 mismatch counts, then a full re-debounce.
    add(1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 0);
    add(1, 1, 1, 8'h02, 8'h00, 8'h00, 8'h00, 0);
    add(5, 0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 0);
    add(1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h00, 1);
    add(1, 0, 1, 8'h02, 8'h02, 8'h00, 8'h00, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      rst = tbl[n].rst;
      ena = tbl[n].ena;
      din = tbl[n].din;
      tick("tbl");
      check($sformatf("tbl[%0d]", n), {dout_a, rise_a, fall_a, changed_a},
            {tbl[n].dout, tbl[n].rise, tbl[n].fall, tbl[n].changed});
    end

    // Short debounce instance: updates land on edge 3.
    rst = 1'b1; ena = 1'b1; din = 8'h00;
    tick("b_rst");
    check_b("b_reset", 8'h00, 8'h00, 8'h00, 0);
    rst = 1'b0; din = 8'h04;
    tick("b_e1"); check_b("b_edge1", 8'h00, 8'h00, 8'h00, 0);
    tick("b_e2"); check_b("b_edge2", 8'h00, 8'h00, 8'h00, 0);
    tick("b_e3"); check_b("b_edge3", 8'h04, 8'h04, 8'h00, 1);
    tick("b_e4"); check_b("b_edge4", 8'h04, 8'h00, 8'h00, 0);
    din = 8'h02;
    tick("b_s1"); check_b("b_swap1", 8'h04, 8'h00, 8'h00, 0);
    tick("b_s2"); check_b("b_swap2", 8'h04, 8'h00, 8'h00, 0);
    tick("b_s3"); check_b("b_swap3", 8'h02, 8'h02, 8'h04, 1);
    tick("b_s4"); check_b("b_swap4", 8'h02, 8'h00, 8'h00, 0);

    // Randomised phase against the model.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) din = din ^ W'($urandom);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
